// File: rtl/logica_cond_pipe.sv
// Conditional-execution unit: NZCV flag register, condition evaluation,
// write-enable gating, optional E-stage register and squash counter.
module logica_cond_pipe #(
  parameter int PIPELINED = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       cond,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic [1:0]       flag_w,
  input  logic [3:0]       ALU_flags,
  input  logic             stall,
  input  logic             flush,
  output logic             PC_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
  } ex_t;

  ex_t  dec_s;
  ex_t  ex_s;
  logic pass;
  logic commit;
  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    dec_s        = '0;
    dec_s.valid  = in_valid & ~flush;
    dec_s.cond   = cond;
    dec_s.pcs    = pcs;
    dec_s.reg_w  = reg_w;
    dec_s.mem_w  = mem_w;
    dec_s.flag_w = flag_w;
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      // flush beats stall: a frozen instruction can still be killed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ex_s <= '0;
        end else if (!stall) begin
          ex_s <= dec_s;
        end else if (flush) begin
          ex_s.valid <= 1'b0;
        end
      end
    end else begin : g_comb
      // reset also masks the combinational path so outputs drop at once
      always_comb begin
        ex_s       = dec_s;
        ex_s.valid = dec_s.valid & rst_n;
      end
    end
  endgenerate

  always_comb begin
    pass = 1'b1;
    case (ex_s.cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

  assign cond_ex   = ex_s.valid & pass;
  assign commit    = ex_s.valid & ~stall & ~flush;
  assign PC_src    = commit & cond_ex & ex_s.pcs;
  assign reg_write = commit & cond_ex & ex_s.reg_w;
  assign mem_write = commit & cond_ex & ex_s.mem_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (commit && cond_ex) begin
      if (ex_s.flag_w[1]) flags[3:2] <= ALU_flags[3:2];
      if (ex_s.flag_w[0]) flags[1:0] <= ALU_flags[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt <= '0;
    end else if (commit && !cond_ex && squash_cnt != '1) begin
      squash_cnt <= squash_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/logica_cond_pipe.md
# logica_cond_pipe

Parametrised conditional-execution unit for the ARM-style processor datapath. It owns the architectural NZCV flag register and evaluates the 4-bit condition field of each instruction against it. It gates the branch, register-write and memory-write enables, updates the flag groups selected per instruction, and optionally registers the decode-side controls into an execute stage with stall/flush control. It sits between the control decoder and the PC mux / register file / data memory write enables, and counts squashed instructions for debug.

## Interface

**Parameters**
- `PIPELINED`, default 1: 1 = decode controls registered into an E-stage register; 0 = controls used combinationally in the same cycle.
- `CNT_W`, default 16: width of the saturating squash counter.

**Ports**
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  decode-side instruction valid.
- `cond`  in  4  condition field, ARM encoding.
- `pcs`  in  1  instruction writes PC.
- `reg_w`  in  1  instruction writes register file.
- `mem_w`  in  1  instruction writes memory.
- `flag_w`  in  2  flag write enables: [1] = N,Z group; [0] = C,V group.
- `ALU_flags`  in  4  ALU flags of the E-stage instruction: [3]=N, [2]=Z, [1]=C, [0]=V.
- `stall`  in  1  freeze E stage and suppress its side effects.
- `flush`  in  1  invalidate E stage.
- `PC_src`  out  1  gated branch/PC write.
- `reg_write`  out  1  gated register write.
- `mem_write`  out  1  gated memory write.
- `cond_ex`  out  1  condition passed for the valid E-stage instruction.
- `flags`  out  4  current NZCV register.
- `squash_cnt`  out  CNT_W  count of valid instructions whose condition failed.

## Operation

**Condition decode** (N,Z,C,V = flag register):
- EQ 0000: Z. NE 0001: !Z.
- CS 0010: C. CC 0011: !C.
- MI 0100: N. PL 0101: !N.
- VS 0110: V. VC 0111: !V.
- HI 1000: C&!Z. LS 1001: !C|Z.
- GE 1010: N==V. LT 1011: N!=V.
- GT 1100: !Z&(N==V). LE 1101: Z|(N!=V).
- AL 1110: 1. 1111: 1.

**E stage**
- PIPELINED=1:
  - E register holds {valid, cond, pcs, reg_w, mem_w, flag_w}.
  - When !stall, it loads the decode inputs, with valid = in_valid & !flush.
  - When stall & !flush, it holds.
  - flush clears valid regardless of stall (flush wins).
- PIPELINED=0: E fields equal the decode inputs directly; valid = in_valid & !flush.

**Gating**
- Define commit = E.valid & !stall & !flush.
- cond_ex = E.valid & condition_true.
- PC_src = commit & cond_ex & E.pcs; reg_write and mem_write are gated the same way.

**Flag update**, on the clock edge when commit & cond_ex:
- E.flag_w[1]: N,Z ← ALU_flags[3:2].
- E.flag_w[0]: C,V ← ALU_flags[1:0].
- The other group is unchanged.

**Squash counter**
- +1 on commit & !cond_ex.
- Saturates at all-ones; no wrap.
- Only reset clears it.

**Stall and flush**
- During a stall the E instruction is frozen: no flag write, no count, all write enables 0.
- It commits in the first cycle stall is low.
- A flushed instruction never commits.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert):
  - flags = 0000, E.valid = 0, squash_cnt = 0.
  - PC_src = reg_write = mem_write = cond_ex = 0.
- Latency with PIPELINED=1: decode inputs at edge k drive the gated outputs during cycle k+1.
- Latency with PIPELINED=0: outputs are combinational from the inputs in the same cycle.
- Flags written at edge k are visible to the condition of the instruction in E during cycle k+1. No forwarding within a cycle: an instruction never sees its own flag result.
- Back-to-back: ADDS then BEQ in consecutive cycles, so BEQ evaluates the ADDS result.
- Reset asserted mid-operation: state clears immediately; outputs fall to 0 without waiting for a clock edge.

## Test plan

- Reset, then each of the 16 cond codes against all 16 NZCV values via preloaded flags → cond_ex matches the decode list (256 checks).
- Flag write: flags=0000; valid AL instruction with flag_w=10 and ALU_flags=1111 → flags=1100. Next instruction with flag_w=01 and ALU_flags=0000 → flags=1100 unchanged, since C,V are already 0.
- Conditional write: flags Z=1; NE with reg_w=1 → reg_write=0 and squash_cnt=1. EQ with reg_w=1 → reg_write=1.
- Stall/flush: EQS held under stall for 3 cycles → outputs 0, flags unchanged. Release → single commit. flush together with stall → instruction dropped, squash_cnt unchanged.
- Saturation: CNT_W=2, five failing instructions → squash_cnt=3.
- PIPELINED=0 build with the same sequences → results identical, shifted one cycle earlier. Async rst_n pulse mid-sequence → all outputs 0 within the same cycle.
